// File: rtl/sys_pkg.sv
// Shared definitions for the system command parser: frame opcodes,
// fixed ALU operand addresses and the parser state encoding.
package sys_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_ADDR   = 4'd1,
    ST_WR_DATA   = 4'd2,
    ST_RD_ADDR   = 4'd3,
    ST_RD_WAIT   = 4'd4,
    ST_ALU_OPA   = 4'd5,
    ST_ALU_OPB   = 4'd6,
    ST_ALU_FUN   = 4'd7,
    ST_ALU_WAIT  = 4'd8,
    ST_PUSH_RD   = 4'd9,
    ST_PUSH_LSB  = 4'd10,
    ST_PUSH_MSB  = 4'd11
  } state_e;

endpackage : sys_pkg

// File: rtl/sys_cmd_parser.sv
// Decodes host command frames into register-file / ALU strobes and pushes
// response bytes (read data or 16-bit ALU result, LSB first) to the TX FIFO.
module sys_cmd_parser
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  output logic [3:0]               ALU_FUN,
  output logic                     ALU_EN,
  output logic                     CLK_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     FIFO_FULL,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     WR_INC
);

  state_e                   state_q,   state_d;
  logic [ADDR_WIDTH-1:0]    addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     wr_en_q,   wr_en_d;
  logic                     rd_en_q,   rd_en_d;
  logic [3:0]               alu_fun_q, alu_fun_d;
  logic                     alu_en_q,  alu_en_d;
  logic                     clk_en_q,  clk_en_d;
  logic [ALU_OUT_WIDTH-1:0] result_q,  result_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     wr_inc_q,  wr_inc_d;
  logic                     push_ok;

  // A push right after another would give back-to-back WR_INC before the
  // FIFO's full flag can reflect the first byte, so one idle cycle is forced.
  assign push_ok = !FIFO_FULL && !wr_inc_q;

  // NOTE: every always_comb output gets its default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    clk_en_d  = clk_en_q;
    result_d  = result_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    wr_inc_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          DATA_WIDTH'(CMD_WR):      state_d = ST_WR_ADDR;
          DATA_WIDTH'(CMD_RD):      state_d = ST_RD_ADDR;
          DATA_WIDTH'(CMD_ALU_OP):  state_d = ST_ALU_OPA;
          DATA_WIDTH'(CMD_ALU_NOP): state_d = ST_ALU_FUN;
          default:                  state_d = ST_IDLE;
        endcase
      end
      ST_WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RD_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (RdData_Valid) begin
        result_d[DATA_WIDTH-1:0] = RdData;
        state_d                  = ST_PUSH_RD;
      end
      ST_ALU_OPA: if (RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(OPA_ADDR);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = ST_ALU_OPB;
      end
      ST_ALU_OPB: if (RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(OPB_ADDR);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = ST_ALU_FUN;
      end
      ST_ALU_FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        clk_en_d  = 1'b1;
        state_d   = ST_ALU_WAIT;
      end
      // A valid coinciding with the function byte is ignored: only ALU_WAIT
      // accepts a result.
      ST_ALU_WAIT: if (ALU_OUT_VLD) begin
        result_d = ALU_OUT;
        clk_en_d = 1'b0;
        state_d  = ST_PUSH_LSB;
      end
      ST_PUSH_RD: if (push_ok) begin
        tx_data_d = result_q[DATA_WIDTH-1:0];
        wr_inc_d  = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_PUSH_LSB: if (push_ok) begin
        tx_data_d = result_q[DATA_WIDTH-1:0];
        wr_inc_d  = 1'b1;
        state_d   = ST_PUSH_MSB;
      end
      ST_PUSH_MSB: if (push_ok) begin
        tx_data_d = result_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
        wr_inc_d  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      result_q  <= '0;
      tx_data_q <= '0;
      wr_inc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      result_q  <= result_d;
      tx_data_q <= tx_data_d;
      wr_inc_q  <= wr_inc_d;
    end
  end

  assign Address = addr_q;
  assign WrData  = wr_data_q;
  assign WrEn    = wr_en_q;
  assign RdEn    = rd_en_q;
  assign ALU_FUN = alu_fun_q;
  assign ALU_EN  = alu_en_q;
  assign CLK_EN  = clk_en_q;
  assign WR_DATA = tx_data_q;
  assign WR_INC  = wr_inc_q;

endmodule : sys_cmd_parser

// File: tb/tb_sys_cmd_parser.sv
// Directed self-checking bench for sys_cmd_parser: drives host frames and
// hand-computed register-file / ALU responses, checks strobes and TX pushes.
module tb_sys_cmd_parser;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [3:0]  Address;
  logic        WrEn, RdEn;
  logic [7:0]  WrData;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, CLK_EN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC;

  int checks = 0;
  int errors = 0;

  int wren_cnt = 0, rden_cnt = 0, aluen_cnt = 0, inc_cnt = 0;
  int overlap_cnt = 0, consec_cnt = 0;
  logic prev_inc = 1'b0;

  sys_cmd_parser dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .WR_DATA(WR_DATA),
    .WR_INC(WR_INC)
  );

  always #5 CLK = ~CLK;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge CLK) begin
    if (WrEn)          wren_cnt++;
    if (RdEn)          rden_cnt++;
    if (ALU_EN)        aluen_cnt++;
    if (WR_INC)        inc_cnt++;
    if (WrEn && RdEn)  overlap_cnt++;
    if (WR_INC && prev_inc) consec_cnt++;
    prev_inc = WR_INC;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge on which the byte's strobes are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Waits (bounded) for a WR_INC sample and checks the pushed byte.
  task automatic expect_push(input string tag, input logic [7:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (WR_INC) found = 1'b1;
      else @(negedge CLK);
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) check({tag, "_data"}, {24'd0, WR_DATA}, {24'd0, exp});
    @(negedge CLK);
  endtask

  int base_wren, base_inc, base_alu;

  initial begin
    // Reset state
    idle(3);
    check("rst_addr",   {28'd0, Address}, 32'd0);
    check("rst_wrdata", {24'd0, WrData}, 32'd0);
    check("rst_strobes", {27'd0, WrEn, RdEn, ALU_EN, CLK_EN, WR_INC}, 32'd0);
    check("rst_wrd",    {24'd0, WR_DATA}, 32'd0);
    check("rst_fun",    {28'd0, ALU_FUN}, 32'd0);
    RST = 1'b1;
    idle(2);

    // Register write: AA 02 81
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h81);
    check("wr_en",   {31'd0, WrEn}, 32'd1);
    check("wr_addr", {28'd0, Address}, 32'd2);
    check("wr_data", {24'd0, WrData}, 32'h81);
    check("wr_rden", {31'd0, RdEn}, 32'd0);
    @(negedge CLK);
    check("wr_en_pulse", {31'd0, WrEn}, 32'd0);
    idle(3); #1;
    check("wr_no_inc", inc_cnt, 32'd0);
    check("wr_en_count", wren_cnt, 32'd1);

    // Register read: BB 03, RdData 0x20 two cycles after RdEn
    send_byte(8'hBB); send_byte(8'h03);
    check("rd_en",   {31'd0, RdEn}, 32'd1);
    check("rd_addr", {28'd0, Address}, 32'd3);
    check("rd_wren", {31'd0, WrEn}, 32'd0);
    @(negedge CLK);
    check("rd_en_pulse", {31'd0, RdEn}, 32'd0);
    RdData = 8'h20; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0; RdData = 8'hFF;
    expect_push("rd_push", 8'h20);
    idle(4); #1;
    check("rd_inc_count", inc_cnt, 32'd1);

    // ALU with operands: CC 01 02 00, result 0x0003
    send_byte(8'hCC); send_byte(8'h01);
    check("opa_wren", {31'd0, WrEn}, 32'd1);
    check("opa_addr", {28'd0, Address}, 32'd0);
    check("opa_data", {24'd0, WrData}, 32'h01);
    send_byte(8'h02);
    check("opb_wren", {31'd0, WrEn}, 32'd1);
    check("opb_addr", {28'd0, Address}, 32'd1);
    check("opb_data", {24'd0, WrData}, 32'h02);
    send_byte(8'h00);
    check("alu_en",  {31'd0, ALU_EN}, 32'd1);
    check("alu_fun", {28'd0, ALU_FUN}, 32'd0);
    check("alu_clken", {31'd0, CLK_EN}, 32'd1);
    check("alu_wren", {31'd0, WrEn}, 32'd0);
    @(negedge CLK);
    check("alu_en_pulse", {31'd0, ALU_EN}, 32'd0);
    check("alu_clken_hold", {31'd0, CLK_EN}, 32'd1);
    ALU_OUT = 16'h0003; ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'hFFFF;
    check("alu_clken_drop", {31'd0, CLK_EN}, 32'd0);
    expect_push("alu_lsb", 8'h03);
    expect_push("alu_msb", 8'h00);
    idle(4); #1;
    check("alu_inc_count", inc_cnt, 32'd3);

    // ALU without operands under FIFO back-pressure: DD 00, result 0x001E
    FIFO_FULL = 1'b1;
    base_wren = wren_cnt;
    send_byte(8'hDD); send_byte(8'h00);
    check("nop_alu_en", {31'd0, ALU_EN}, 32'd1);
    check("nop_clken",  {31'd0, CLK_EN}, 32'd1);
    @(negedge CLK);
    ALU_OUT = 16'h001E; ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'h0000;
    base_inc = inc_cnt;
    idle(5); #1;
    check("full_no_inc",  inc_cnt, base_inc);
    check("full_wr_data", {24'd0, WR_DATA}, 32'h00);
    check("nop_no_wren",  wren_cnt, base_wren);
    FIFO_FULL = 1'b0;
    expect_push("full_lsb", 8'h1E);
    expect_push("full_msb", 8'h00);

    // Unknown opcode dropped, then write AA 00 0F
    base_wren = wren_cnt;
    send_byte(8'h55);
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h0F);
    check("junk_wren", {31'd0, WrEn}, 32'd1);
    check("junk_addr", {28'd0, Address}, 32'd0);
    check("junk_data", {24'd0, WrData}, 32'h0F);
    idle(2); #1;
    check("junk_wren_count", wren_cnt, base_wren + 1);

    // Reset mid-command: CC 07, reset, then AA 01 33
    send_byte(8'hCC); send_byte(8'h07);
    check("mid_opa_data", {24'd0, WrData}, 32'h07);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, WrData}, 32'h00);
    check("mid_rst_wren", {31'd0, WrEn}, 32'd0);
    idle(2);
    RST = 1'b1;
    base_wren = wren_cnt;
    base_alu  = aluen_cnt;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h33);
    check("post_rst_wren", {31'd0, WrEn}, 32'd1);
    check("post_rst_addr", {28'd0, Address}, 32'd1);
    check("post_rst_data", {24'd0, WrData}, 32'h33);
    idle(4); #1;
    check("post_rst_wren_count", wren_cnt, base_wren + 1);
    check("post_rst_no_alu", aluen_cnt, base_alu);

    // Global invariants
    check("wren_rden_overlap", overlap_cnt, 32'd0);
    check("wr_inc_back_to_back", consec_cnt, 32'd0);
    check("total_rden", rden_cnt, 32'd1);
    check("total_inc", inc_cnt, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sys_cmd_parser

// File: doc/sys_cmd_parser.md
Name: sys_cmd_parser

Overview:
Command front end in the REF_CLK domain, directly downstream of the UART receiver's data-sync stage. Consumes received bytes and decodes the frame protocol: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands. Drives the register-file and ALU control strobes. Pushes response bytes (read data, 16-bit ALU result LSB first) into the async TX FIFO feeding UART TX.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX data and register-file data
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
ALU_OUT_WIDTH, 16, ALU result width; must be 2*DATA_WIDTH

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD=1
RX_D_VLD  in  1  one-cycle pulse per received byte, already synchronized to CLK
Address  out  ADDR_WIDTH  register-file address
WrEn  out  1  register-file write strobe, one cycle
RdEn  out  1  register-file read strobe, one cycle
WrData  out  DATA_WIDTH  register-file write data
RdData  in  DATA_WIDTH  register-file read data
RdData_Valid  in  1  read data valid pulse
ALU_FUN  out  4  ALU function code
ALU_EN  out  1  ALU start strobe, one cycle
CLK_EN  out  1  ALU clock-gate enable
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
FIFO_FULL  in  1  TX FIFO full
WR_DATA  out  DATA_WIDTH  byte pushed to TX FIFO
WR_INC  out  1  TX FIFO push strobe, one cycle

Behaviour:
- Reset (RST=0, async): state=IDLE. All outputs 0: Address, WrData, ALU_FUN, WR_DATA, and every strobe. Reset mid-command abandons the command. No partial strobe issues after release.
- All outputs are registered. Each strobe fires in the cycle after the RX_D_VLD that completes its field.
- IDLE: on RX_D_VLD, 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_OPA, 0xDD->ALU_FUN_S. Any other byte is dropped and the state stays IDLE.
- WR_ADDR: on byte, latch Address=byte[ADDR_WIDTH-1:0]->WR_DATA_S.
- WR_DATA_S: on byte, WrData=byte, WrEn=1 for one cycle->IDLE.
- RD_ADDR: on byte, latch Address, RdEn=1 for one cycle->RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData->PUSH_RD.
- ALU_OPA: on byte, Address=0, WrData=byte, WrEn pulse->ALU_OPB.
- ALU_OPB: on byte, Address=1, WrData=byte, WrEn pulse->ALU_FUN_S.
- ALU_FUN_S: on byte, ALU_FUN=byte[3:0], ALU_EN pulse, CLK_EN=1->ALU_WAIT.
- ALU_WAIT: CLK_EN held at 1. On ALU_OUT_VLD, capture ALU_OUT, drop CLK_EN->PUSH_LSB.
- PUSH_RD: when FIFO_FULL=0, WR_DATA=captured RdData, WR_INC pulse->IDLE.
- PUSH_LSB: when FIFO_FULL=0, WR_DATA=result[7:0], WR_INC pulse->PUSH_MSB.
- PUSH_MSB: when FIFO_FULL=0, WR_DATA=result[15:8], WR_INC pulse->IDLE.
- FIFO_FULL=1 in a push state stalls with WR_INC=0 and WR_DATA held. The push fires in the first cycle after FIFO_FULL is seen low.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or a push state: the byte is dropped. This is not an error. Host pacing guarantees the gap.
- RdData_Valid/ALU_OUT_VLD outside their wait states: ignored.
- WrEn and RdEn are never high together. WR_INC is never high in two consecutive cycles.
- ALU_OUT_VLD in the same cycle that CLK_EN rises: accepted only once in ALU_WAIT. The ALU takes at least 1 cycle.

Decomposition:
- Shared package sys_pkg: command opcode constants (CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD), state encoding constants, OPA_ADDR=0, OPB_ADDR=1.
- Single FSM module, no sub-module. The push logic stays inline: it is one registered mux.

Test Plan:
- Bytes 0xAA,0x02,0x81 -> one-cycle WrEn with Address=2, WrData=0x81. No WR_INC.
- Bytes 0xBB,0x03; model returns RdData=0x20 with RdData_Valid 2 cycles after RdEn -> RdEn with Address=3, then a single WR_INC with WR_DATA=0x20.
- Bytes 0xCC,0x01,0x02,0x00 -> WrEn at Address 0 data 0x01, then WrEn at Address 1 data 0x02, then ALU_EN with ALU_FUN=0 and CLK_EN high. Model returns ALU_OUT=0x0003 -> WR_INC 0x03 then WR_INC 0x00, with CLK_EN low after VLD.
- Bytes 0xDD,0x00 with ALU_OUT=0x001E; FIFO_FULL held high 5 cycles -> no WR_INC while full, then 0x1E, then 0x00 pushed in order.
- Byte 0x55 in IDLE, then 0xAA,0x00,0x0F -> 0x55 ignored; single WrEn at Address 0 data 0x0F.
- Bytes 0xCC,0x07, then RST low mid-command, then 0xAA,0x01,0x33 -> after reset no ALU_EN or second operand write; only WrEn at Address 1 data 0x33.
